uc_compara_tiros_com_asteroides: RTL and testbench

//  Control unit for the shot-vs-asteroid collision pass. It is triggered by the asteroid/ship

---
 rtl/astro_pkg.sv | 35 +++
 rtl/uc_compara_tiros_com_asteroides_if.sv | 36 +++
 rtl/contador_mod_n.sv | 24 ++
 rtl/uc_compara_tiros_com_asteroides.sv | 113 +++++++++++
 tb/tb_uc_compara_tiros_com_asteroides.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/astro_pkg.sv
// Shared definitions for the asteroid game control units: slot counts, state codes
// and the output bundle of the shot-vs-asteroid collision pass.
package astro_pkg;

   localparam int unsigned N_TIROS      = 4;
   localparam int unsigned N_ASTEROIDES = 16;
   localparam int unsigned W_TIRO       = $clog2(N_TIROS);
   localparam int unsigned W_AST        = $clog2(N_ASTEROIDES);
   localparam int unsigned W_ESTADO     = 5;

   typedef enum logic [W_ESTADO-1:0] {
      INICIO    = 5'd0,
      ESPERA    = 5'd1,
      ZERA      = 5'd2,
      LE        = 5'd3,
      COMPARA   = 5'd4,
      DESTROI   = 5'd5,
      PROX_AST  = 5'd6,
      PROX_TIRO = 5'd7,
      FIM       = 5'd8
   } estado_t;

   localparam logic [W_ESTADO-1:0] DB_INVALIDO = 5'h0F;

   typedef struct packed {
      logic                enable_mem_tiro;
      logic                enable_mem_asteroide;
      logic                new_loaded_tiro;
      logic                new_destruido_asteroide;
      logic                incrementa_pontos;
      logic                fim_compara_tiros_e_asteroides;
      logic [W_ESTADO-1:0] db_estado_compara_tiros;
   } saidas_t;

endpackage

// File: rtl/uc_compara_tiros_com_asteroides_if.sv
// Handshake with the upstream UC plus the shot/asteroid memory ports.
interface uc_compara_tiros_com_asteroides_if;
   import astro_pkg::*;

   logic                sinal_compara_tiros_e_asteroide;
   logic                tiro_loaded;
   logic                asteroide_loaded;
   logic                asteroide_destruido;
   logic                posicao_tiro_igual_asteroide;
   logic [W_TIRO-1:0]   endereco_tiro;
   logic [W_AST-1:0]    endereco_asteroide;
   logic                enable_mem_tiro;
   logic                enable_mem_asteroide;
   logic                new_loaded_tiro;
   logic                new_destruido_asteroide;
   logic                incrementa_pontos;
   logic                fim_compara_tiros_e_asteroides;
   logic [W_ESTADO-1:0] db_estado_compara_tiros;

   modport master (
      input  sinal_compara_tiros_e_asteroide, tiro_loaded, asteroide_loaded,
             asteroide_destruido, posicao_tiro_igual_asteroide,
      output endereco_tiro, endereco_asteroide, enable_mem_tiro, enable_mem_asteroide,
             new_loaded_tiro, new_destruido_asteroide, incrementa_pontos,
             fim_compara_tiros_e_asteroides, db_estado_compara_tiros
   );

   modport slave (
      output sinal_compara_tiros_e_asteroide, tiro_loaded, asteroide_loaded,
             asteroide_destruido, posicao_tiro_igual_asteroide,
      input  endereco_tiro, endereco_asteroide, enable_mem_tiro, enable_mem_asteroide,
             new_loaded_tiro, new_destruido_asteroide, incrementa_pontos,
             fim_compara_tiros_e_asteroides, db_estado_compara_tiros
   );

endinterface

// File: rtl/contador_mod_n.sv
// Modulo-N index counter with synchronous clear and count enable; rco flags the last index.
module contador_mod_n #(
   parameter int unsigned N = 16,
   parameter int unsigned W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   output logic [W-1:0] Q,
   output logic         rco
);

   localparam logic [W-1:0] ULTIMO = W'(N - 1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)     Q <= '0;
      else if (zera)  Q <= '0;
      else if (conta) Q <= (Q == ULTIMO) ? '0 : Q + W'(1);
   end

   assign rco = (Q == ULTIMO);

endmodule

// File: rtl/uc_compara_tiros_com_asteroides.sv
// Collision-pass control unit: sweeps every (shot, asteroid) pair, unloading the shot and
// destroying the asteroid on a hit, then reports completion to the upstream UC.
module uc_compara_tiros_com_asteroides
   import astro_pkg::*;
(
   input  logic                                clock,
   input  logic                                reset,
   uc_compara_tiros_com_asteroides_if.master   bus
);

   estado_t           estado, prox_estado;
   saidas_t           saidas;
   logic              zera_tiro, conta_tiro, zera_ast, conta_ast;
   logic              rco_tiro, rco_ast;
   logic [W_TIRO-1:0] idx_tiro;
   logic [W_AST-1:0]  idx_ast;

   contador_mod_n #(.N(N_TIROS), .W(W_TIRO)) u_cont_tiro (
      .clock (clock), .reset (reset), .zera (zera_tiro), .conta (conta_tiro),
      .Q (idx_tiro), .rco (rco_tiro)
   );

   contador_mod_n #(.N(N_ASTEROIDES), .W(W_AST)) u_cont_ast (
      .clock (clock), .reset (reset), .zera (zera_ast), .conta (conta_ast),
      .Q (idx_ast), .rco (rco_ast)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) estado <= INICIO;
      else        estado <= prox_estado;
   end

   // Next state and counter control; counters step on the exit edge of their state.
   always_comb begin
      prox_estado = estado;
      zera_tiro   = 1'b0;
      conta_tiro  = 1'b0;
      zera_ast    = 1'b0;
      conta_ast   = 1'b0;
      case (estado)
         INICIO:  prox_estado = ESPERA;
         ESPERA:  if (bus.sinal_compara_tiros_e_asteroide) prox_estado = ZERA;
         ZERA: begin
            zera_tiro   = 1'b1;
            zera_ast    = 1'b1;
            prox_estado = LE;
         end
         LE:      prox_estado = COMPARA;
         COMPARA: begin
            if (!bus.tiro_loaded)
               prox_estado = PROX_TIRO;
            else if (bus.asteroide_loaded && !bus.asteroide_destruido &&
                     bus.posicao_tiro_igual_asteroide)
               prox_estado = DESTROI;
            else
               prox_estado = PROX_AST;
         end
         DESTROI: prox_estado = PROX_TIRO;
         PROX_AST: begin
            if (rco_ast) begin
               prox_estado = PROX_TIRO;
            end else begin
               conta_ast   = 1'b1;
               prox_estado = LE;
            end
         end
         PROX_TIRO: begin
            if (rco_tiro) begin
               prox_estado = FIM;
            end else begin
               conta_tiro  = 1'b1;
               zera_ast    = 1'b1;
               prox_estado = LE;
            end
         end
         FIM:     prox_estado = ESPERA;
         default: prox_estado = INICIO;
      endcase
   end

   // Moore decode of the state register.
   always_comb begin
      saidas                 = '0;
      saidas.new_loaded_tiro = 1'b1;
      case (estado)
         DESTROI: begin
            saidas.enable_mem_tiro         = 1'b1;
            saidas.enable_mem_asteroide    = 1'b1;
            saidas.new_loaded_tiro         = 1'b0;
            saidas.new_destruido_asteroide = 1'b1;
            saidas.incrementa_pontos       = 1'b1;
         end
         FIM:     saidas.fim_compara_tiros_e_asteroides = 1'b1;
         default: ;
      endcase
      case (estado)
         INICIO, ESPERA, ZERA, LE, COMPARA, DESTROI, PROX_AST, PROX_TIRO, FIM:
                  saidas.db_estado_compara_tiros = estado;
         default: saidas.db_estado_compara_tiros = DB_INVALIDO;
      endcase
   end

   assign bus.endereco_tiro                  = idx_tiro;
   assign bus.endereco_asteroide             = idx_ast;
   assign bus.enable_mem_tiro                = saidas.enable_mem_tiro;
   assign bus.enable_mem_asteroide           = saidas.enable_mem_asteroide;
   assign bus.new_loaded_tiro                = saidas.new_loaded_tiro;
   assign bus.new_destruido_asteroide        = saidas.new_destruido_asteroide;
   assign bus.incrementa_pontos              = saidas.incrementa_pontos;
   assign bus.fim_compara_tiros_e_asteroides = saidas.fim_compara_tiros_e_asteroides;
   assign bus.db_estado_compara_tiros        = saidas.db_estado_compara_tiros;

endmodule

// File: tb/tb_uc_compara_tiros_com_asteroides.sv
// Scoreboard bench for the collision-pass UC: a pair-by-pair sweep model predicts every
// compare visit, hit write and done pulse with its cycle; a monitor matches what the DUT shows.
module tb_uc_compara_tiros_com_asteroides;
   import astro_pkg::*;

   localparam int NT = int'(N_TIROS);
   localparam int NA = int'(N_ASTEROIDES);

   typedef enum int {EV_VISIT, EV_HIT, EV_FIM} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       tiro;
      int       ast;
      int       cyc;
   } ev_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   uc_compara_tiros_com_asteroides_if bus ();

   uc_compara_tiros_com_asteroides dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   int  cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   ev_t q[$];
   int  checks   = 0;
   int  failures = 0;

   // Memories seen by the DUT; flags it can rewrite are loaded through this same process.
   logic [NT-1:0] mem_tl, cfg_tl;
   logic [NA-1:0] mem_al, mem_ad, cfg_ad;
   logic [7:0]    pos_t [NT];
   logic [7:0]    pos_a [NA];
   logic          load = 1'b0;

   always @(posedge clock) begin
      if (load) begin
         mem_tl <= cfg_tl;
         mem_ad <= cfg_ad;
      end else begin
         if (bus.enable_mem_tiro)      mem_tl[bus.endereco_tiro]      <= bus.new_loaded_tiro;
         if (bus.enable_mem_asteroide) mem_ad[bus.endereco_asteroide] <= bus.new_destruido_asteroide;
      end
   end

   always_comb begin
      bus.tiro_loaded                  = mem_tl[bus.endereco_tiro];
      bus.asteroide_loaded             = mem_al[bus.endereco_asteroide];
      bus.asteroide_destruido          = mem_ad[bus.endereco_asteroide];
      bus.posicao_tiro_igual_asteroide = (pos_t[bus.endereco_tiro] == pos_a[bus.endereco_asteroide]);
   end

   // Model's view of the rewritable flags.
   logic [NT-1:0] m_tl;
   logic [NA-1:0] m_ad;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic void push_ev(input ev_kind_t k, input int ti, input int a, input int c);
      ev_t e;
      e.kind = k; e.tiro = ti; e.ast = a; e.cyc = c;
      q.push_back(e);
   endfunction

   // Sweep whose request is seen in the idle cycle s: 1 idle + 1 clear cycle, then each pair
   // costs read+compare+advance, a hit ends that shot, and each shot ends with one step.
   task automatic model_sweep(input int s, output int fim_c, output int hit_c);
      int  t;
      bit  hit;
      t     = s + 2;
      hit_c = -1;
      for (int ti = 0; ti < NT; ti++) begin
         if (!m_tl[ti]) begin
            push_ev(EV_VISIT, ti, 0, t + 1);
            t += 3;
            continue;
         end
         hit = 1'b0;
         for (int a = 0; a < NA; a++) begin
            push_ev(EV_VISIT, ti, a, t + 1);
            if (mem_al[a] && !m_ad[a] && pos_t[ti] == pos_a[a]) begin
               push_ev(EV_HIT, ti, a, t + 2);
               hit_c    = t + 2;
               m_tl[ti] = 1'b0;
               m_ad[a]  = 1'b1;
               t += 4;
               hit = 1'b1;
               break;
            end
            t += 3;
         end
         if (!hit) t += 1;
      end
      push_ev(EV_FIM, 0, 0, t);
      fim_c = t;
   endtask

   always @(negedge clock) begin : monitor
      bit       vis, hit, fim;
      ev_kind_t k;
      ev_t      e;
      if (reset) begin
         vis = (bus.db_estado_compara_tiros == 5'd4);
         hit = bus.enable_mem_tiro | bus.enable_mem_asteroide | bus.incrementa_pontos;
         fim = bus.fim_compara_tiros_e_asteroides;
         if (vis | hit | fim) begin
            k = hit ? EV_HIT : (fim ? EV_FIM : EV_VISIT);
            if (q.size() == 0) begin
               chk("unexpected_event", 64'(k), 64'hFF);
            end else begin
               e = q.pop_front();
               chk("event_kind", 64'(k), 64'(e.kind));
               chk("event_cycle", 64'(cyc), 64'(e.cyc));
               if (k != EV_FIM)
                  chk("event_addr", {32'(bus.endereco_tiro), 32'(bus.endereco_asteroide)},
                      {32'(e.tiro), 32'(e.ast)});
               if (k == EV_HIT)
                  chk("hit_strobes", 64'({bus.enable_mem_tiro, bus.enable_mem_asteroide,
                      bus.new_loaded_tiro, bus.new_destruido_asteroide, bus.incrementa_pontos}),
                      64'(5'b11011));
            end
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   task automatic load_scenario(input logic [NT-1:0] tl, input logic [NA-1:0] al,
                                input logic [NA-1:0] ad);
      @(negedge clock);
      mem_al = al;
      cfg_tl = tl;
      cfg_ad = ad;
      load   = 1'b1;
      @(negedge clock);
      load   = 1'b0;
      m_tl   = tl;
      m_ad   = ad;
   endtask

   task automatic run_sweep(input int pulse_mid, output int fim_c, output int hit_c);
      int s;
      @(negedge clock);
      s = cyc;
      model_sweep(s, fim_c, hit_c);
      bus.sinal_compara_tiros_e_asteroide = 1'b1;
      @(negedge clock);
      bus.sinal_compara_tiros_e_asteroide = 1'b0;
      if (pulse_mid > 0) begin
         wait_until(s + pulse_mid);
         bus.sinal_compara_tiros_e_asteroide = 1'b1;
         @(negedge clock);
         bus.sinal_compara_tiros_e_asteroide = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_db"}, 64'(bus.db_estado_compara_tiros), 64'(0));
      chk({tag, "_addr"}, 64'({bus.endereco_tiro, bus.endereco_asteroide}), 64'(0));
      chk({tag, "_strobes"}, 64'({bus.enable_mem_tiro, bus.enable_mem_asteroide,
          bus.new_destruido_asteroide, bus.incrementa_pontos,
          bus.fim_compara_tiros_e_asteroides}), 64'(0));
      chk({tag, "_new_loaded"}, 64'(bus.new_loaded_tiro), 64'(1));
   endtask

   initial begin : watchdog
      repeat (60000) @(posedge clock);
      failures++;
      $display("FAIL watchdog: bench did not complete within cycle budget");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : stim
      int fim_c, hit_c, s, f1, f2, h;
      bus.sinal_compara_tiros_e_asteroide = 1'b0;
      mem_al = '0;
      cfg_tl = '0;
      cfg_ad = '0;
      for (int i = 0; i < NT; i++) pos_t[i] = 8'(8'h80 + i);
      for (int i = 0; i < NA; i++) pos_a[i] = 8'(i);
      repeat (2) @(negedge clock);
      check_reset_outputs("reset_state");

      // Shot 1 aimed at asteroid 5; reset lands in the middle of the hit cycle.
      pos_t[1] = 8'd5;
      load_scenario(4'b0010, '1, '0);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      run_sweep(0, fim_c, hit_c);
      wait_until(hit_c - 1);
      @(posedge clock);
      #2 reset = 1'b0;
      #1 check_reset_outputs("reset_mid_hit");
      q.delete();
      @(negedge clock);
      chk("no_partial_write", 64'({mem_tl[1], mem_ad[5]}), 64'(2'b10));
      m_tl = mem_tl;
      m_ad = mem_ad;
      reset = 1'b1;
      repeat (3) @(negedge clock);

      // Same scenario swept cleanly from index 0.
      run_sweep(0, fim_c, hit_c);
      wait_until(fim_c + 2);

      // All shots unloaded: short sweep, one visit per shot.
      load_scenario('0, '1, '0);
      run_sweep(0, fim_c, hit_c);
      wait_until(fim_c + 2);

      // Position match against an already destroyed asteroid.
      pos_t[1] = 8'h81;
      pos_t[0] = 8'd7;
      load_scenario(4'b0001, '1, 16'h0080);
      run_sweep(0, fim_c, hit_c);
      wait_until(fim_c + 2);

      // Shots 0 and 3 hit distinct asteroids.
      pos_t[0] = 8'd3;
      pos_t[3] = 8'd9;
      load_scenario(4'b1001, '1, '0);
      run_sweep(0, fim_c, hit_c);
      wait_until(fim_c + 3);
      chk("idle_after_two_hits", 64'(bus.db_estado_compara_tiros), 64'(1));

      // Request pulsed while busy must be ignored.
      pos_t[2] = 8'd10;
      load_scenario(4'b0100, '1, '0);
      run_sweep(12, fim_c, hit_c);
      wait_until(fim_c + 4);
      chk("busy_start_ignored", 64'(bus.db_estado_compara_tiros), 64'(1));

      // Randomized sweeps over a small position space so collisions are frequent.
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < NT; i++) pos_t[i] = 8'($urandom_range(0, 7));
         for (int i = 0; i < NA; i++) pos_a[i] = 8'($urandom_range(0, 7));
         load_scenario(NT'($urandom), NA'($urandom), NA'($urandom));
         run_sweep(0, fim_c, hit_c);
         wait_until(fim_c + 2);
      end

      // Request held through the done pulse: a second sweep starts right after it.
      for (int i = 0; i < NT; i++) pos_t[i] = 8'($urandom_range(0, 3));
      for (int i = 0; i < NA; i++) pos_a[i] = 8'($urandom_range(0, 3));
      load_scenario('1, NA'($urandom), '0);
      @(negedge clock);
      s = cyc;
      model_sweep(s, f1, h);
      model_sweep(f1 + 1, f2, h);
      bus.sinal_compara_tiros_e_asteroide = 1'b1;
      wait_until(f2);
      bus.sinal_compara_tiros_e_asteroide = 1'b0;
      wait_until(f2 + 3);
      chk("idle_after_held_start", 64'(bus.db_estado_compara_tiros), 64'(1));
      chk("final_shot_flags", 64'(mem_tl), 64'(m_tl));
      chk("final_destroyed_flags", 64'(mem_ad), 64'(m_ad));
      chk("queue_drained", 64'(q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
